// File: rtl/mmio_timer_digi.sv
// mmio_timer_digi: bus-mapped reload timer with irq, free-running tick and 4-digit hex 7-segment scanner.
module mmio_timer_digi #(
  parameter logic [31:0] BASE = 32'h40000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iRd,
  input  logic        iWr,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWrData,
  output logic [31:0] oRdData,
  output logic        oHit,
  output logic        oIrq,
  output logic [11:0] oDigi
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [31:0] r_th, r_tl, r_tick;
  logic [2:0]  r_tcon;
  logic [15:0] r_digi;
  logic [CW-1:0] r_scan;
  logic [1:0]  r_idx;
  logic        r_irq;
  logic [11:0] r_out;
  logic [31:0] w_sub;
  logic [2:0]  w_off;
  logic [7:0]  w_we;
  logic        w_ovf, w_scan_end;
  logic [3:0]  w_nib;
  // Unsigned wrap makes addresses below BASE land far outside the window.
  assign w_sub = iAddr - BASE;
  assign w_off = w_sub[4:2];
  assign oHit = w_sub < 32'd32;
  assign w_we = (iWr && oHit) ? 8'd1 << w_off : 8'd0;
  assign w_ovf = r_tcon[0] && (r_tl == 32'hFFFFFFFF) && !w_we[1];
  assign w_scan_end = r_scan == CW'(SCAN_DIV - 1);
  assign w_nib = r_digi[{r_idx, 2'b00} +: 4];
  always_comb begin
    oRdData = !(iRd && oHit) ? 32'h0 :
              w_off == 3'd0 ? r_th :
              w_off == 3'd1 ? r_tl :
              w_off == 3'd2 ? {29'h0, r_tcon} :
              w_off == 3'd4 ? {16'h0, r_digi} :
              w_off == 3'd5 ? r_tick : 32'h0;
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_th   <= '0;
      r_tl   <= '0;
      r_tcon <= '0;
      r_digi <= '0;
      r_tick <= '0;
      r_scan <= '0;
      r_idx  <= '0;
      r_irq  <= 1'b0;
      r_out  <= 12'hEC0;
    end else begin
      r_tick <= r_tick + 32'd1;
      r_irq  <= r_tcon[1] & r_tcon[2];
      if (w_we[0]) r_th <= iWrData;
      r_tl <= w_we[1] ? iWrData : w_ovf ? r_th : r_tcon[0] ? r_tl + 32'd1 : r_tl;
      if (w_we[2]) r_tcon[1:0] <= iWrData[1:0];
      r_tcon[2] <= w_ovf | (r_tcon[2] & ~(w_we[2] & iWrData[2]));
      if (w_we[4]) r_digi <= iWrData[15:0];
      r_scan <= w_scan_end ? '0 : r_scan + CW'(1);
      if (w_scan_end) r_idx <= r_idx + 2'd1;
      r_out <= {~(4'b0001 << r_idx), SEG[w_nib]};
    end
  end
  assign oIrq  = r_irq;
  assign oDigi = r_out;
endmodule

// File: tb/tb_mmio_timer_digi.sv
// tb_mmio_timer_digi: directed bench for the timer/tick/scanner peripheral with SCAN_DIV=2.
module tb_mmio_timer_digi;
  localparam logic [31:0] B = 32'h40000000;
  logic iClk, iRst, iRd, iWr, oHit, oIrq;
  logic [31:0] iAddr, iWrData, oRdData;
  logic [11:0] oDigi;
  int n_chk, n_bad, cyc;
  mmio_timer_digi #(.BASE(B), .SCAN_DIV(2)) dut (
    .iClk(iClk), .iRst(iRst), .iRd(iRd), .iWr(iWr), .iAddr(iAddr), .iWrData(iWrData),
    .oRdData(oRdData), .oHit(oHit), .oIrq(oIrq), .oDigi(oDigi)
  );
  initial begin
    iClk = 0;
    forever #5 iClk = ~iClk;
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge iClk);
    #1;
    cyc++;
  endtask
  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    iAddr = B + 32'(off);
    iWrData = d;
    iWr = 1;
    tick();
    iWr = 0;
  endtask
  task automatic rdchk(input string tag, input logic [7:0] off, input logic [31:0] exp);
    iAddr = B + 32'(off);
    iRd = 1;
    #1;
    chk(tag, oRdData, exp);
    iRd = 0;
  endtask
  initial begin
    logic [11:0] seq [8];
    seq = '{12'hDB0, 12'hDB0, 12'hBA4, 12'hBA4, 12'h7F9, 12'h7F9, 12'hE99, 12'hE99};
    n_chk = 0; n_bad = 0; cyc = 0;
    iRst = 1; iRd = 0; iWr = 0; iAddr = 0; iWrData = 0;
    #1;
    tick(); tick();
    iRst = 0; cyc = 0;
    chk("rst_digi", 32'(oDigi), 32'hEC0);
    chk("rst_irq", 32'(oIrq), 0);
    rdchk("rst_tcon", 8'h08, 0);
    repeat (5) tick();
    rdchk("tick5", 8'h14, 5);
    wr(8'h00, 32'hFFFFFFFD);
    wr(8'h04, 32'hFFFFFFFE);
    wr(8'h08, 32'h3);
    rdchk("tl_a", 8'h04, 32'hFFFFFFFE);
    tick();
    rdchk("tl_b", 8'h04, 32'hFFFFFFFF);
    rdchk("tcon_pre", 8'h08, 3);
    tick();
    rdchk("tl_wrap", 8'h04, 32'hFFFFFFFD);
    rdchk("tcon_st", 8'h08, 7);
    chk("irq_lag", 32'(oIrq), 0);
    tick();
    chk("irq_set", 32'(oIrq), 1);
    rdchk("tl_c", 8'h04, 32'hFFFFFFFE);
    tick();
    rdchk("tl_d", 8'h04, 32'hFFFFFFFF);
    tick();
    rdchk("tl_wrap2", 8'h04, 32'hFFFFFFFD);
    wr(8'h08, 32'h6);
    rdchk("tcon_clr", 8'h08, 2);
    rdchk("tl_e", 8'h04, 32'hFFFFFFFE);
    tick();
    chk("irq_clr", 32'(oIrq), 0);
    rdchk("tl_hold", 8'h04, 32'hFFFFFFFE);
    wr(8'h04, 32'hFFFFFFFE);
    wr(8'h08, 32'h1);
    tick();
    wr(8'h08, 32'h5);
    rdchk("set_wins", 8'h08, 5);
    rdchk("tl_reload", 8'h04, 32'hFFFFFFFD);
    iAddr = B + 32'h20; iRd = 1;
    #1;
    chk("hit_out", 32'(oHit), 0);
    chk("rd_out", oRdData, 0);
    iAddr = B - 32'h4;
    #1;
    chk("hit_below", 32'(oHit), 0);
    iAddr = B + 32'h1C;
    #1;
    chk("hit_top", 32'(oHit), 1);
    iRd = 0;
    rdchk("tick_pre", 8'h14, 32'(cyc));
    wr(8'h14, 32'hFFFFFFFF);
    rdchk("tick_ro", 8'h14, 32'(cyc));
    wr(8'h0C, 32'hFFFFFFFF);
    rdchk("rsvd", 8'h0C, 0);
    wr(8'h10, 32'hABCD0123);
    rdchk("digi", 8'h10, 32'h123);
    iAddr = B + 32'h10; iWrData = 32'h55AA; iWr = 1; iRd = 1;
    #1;
    chk("rd_pre_edge", oRdData, 32'h123);
    tick();
    iWr = 0;
    #1;
    chk("rd_post_edge", oRdData, 32'h55AA);
    iRd = 0;
    iAddr = B + 32'h04; iWrData = 32'h1234; iWr = 1; iRst = 1;
    tick();
    iWr = 0; iRst = 0; cyc = 0;
    rdchk("rst_tl", 8'h04, 0);
    rdchk("rst_tcon2", 8'h08, 0);
    rdchk("rst_digi_reg", 8'h10, 0);
    chk("rst_digi2", 32'(oDigi), 32'hEC0);
    wr(8'h10, 32'h1234);
    chk("scan_old", 32'(oDigi), 32'hEC0);
    tick();
    chk("scan_first", 32'(oDigi), 32'hE99);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("scan%0d", i), 32'(oDigi), 32'(seq[i]));
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/mmio_timer_digi.md
Name: mmio_timer_digi

Overview:
Memory-mapped peripheral responder on the data-memory bus driven by the single-cycle core. It answers core load/store cycles (iRd/iWr/iAddr/iWrData -> oRdData) for a programmable reload timer with interrupt, a free-running system tick, and a 4-digit hex value register. It autonomously scans that value onto the multiplexed 7-segment outputs (oDigi). It sits beside the data memory and shares the same bus signals, which the top level decodes by address.

Parameters:
BASE, 32'h40000000, byte base address of the 32-byte register window
SCAN_DIV, 50000, clock cycles each digit stays lit (must be >= 1)

Ports:
iClk  in  1  system clock, all state updates on the rising edge
iRst  in  1  synchronous reset, active-high
iRd  in  1  core load strobe
iWr  in  1  core store strobe
iAddr  in  32  byte address; bits [1:0] ignored
iWrData  in  32  store data
oRdData  out  32  load data, combinational
oHit  out  1  iAddr within [BASE, BASE+0x1F]; combinational, independent of iRd/iWr
oIrq  out  1  timer interrupt request
oDigi  out  12  {anode_n[3:0], seg_n[7:0]}, both active-low

Behaviour:
- Register map (offset from BASE): 0x00 TH reload (RW); 0x04 TL count (RW); 0x08 TCON (RW) [0]=enable [1]=irq_en [2]=status (W1C); 0x0C reserved (reads 0, writes ignored); 0x10 DIGI (RW, bits [15:0] kept, upper bits read 0); 0x14 SYSTICK (RO, writes ignored); 0x18-0x1C reserved.
- Reads: oRdData = selected register when iRd && oHit; otherwise 32'h0. Same-cycle, zero latency, as the single-cycle core requires. A read in the same cycle as a store returns the pre-edge value.
- Writes: take effect on the edge where iWr && oHit. iRd and iWr together: the write still occurs.
- TL: when TCON[0]=1 and not being written, TL increments by 1 each cycle. If TL == 32'hFFFFFFFF, the next TL = TH and status is set. A TL write overrides counting that cycle. A TH write is only used at the next reload.
- TCON write: bits [1:0] load from iWrData[1:0]. iWrData[2]=1 clears status. An overflow in the same cycle as a clear leaves status=1 (set wins).
- oIrq: registered output = TCON[1] & TCON[2] as of the prior edge. It rises 1 cycle after status sets.
- SYSTICK: increments every cycle and wraps modulo 2^32.
- Scanner:
  - scan_cnt counts 0..SCAN_DIV-1. On reaching SCAN_DIV-1, it returns to 0 and digit index idx (2-bit) advances 0->1->2->3->0.
  - anode_n = ~(4'b0001 << idx).
  - seg_n = hex decode of DIGI[4*idx+3 : 4*idx], with bit7 (dp) = 1 and bits[6:0] = gfedcba active-low.
  - Decode 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
  - oDigi is registered from idx/DIGI, so a DIGI write appears on the following edge.
- Reset values: TH=TL=TCON=DIGI=SYSTICK=0; scan_cnt=0; idx=0; oIrq=0; oDigi=12'hEC0. Reset mid-count or mid-scan restores all of these on that edge and ignores a concurrent iWr.

Test Plan:
1. Reset asserted, then released, no bus activity -> oDigi=12'hEC0, oIrq=0; a read of 0x08 returns 0; SYSTICK read 5 cycles after release returns 5.
2. Write TH=FFFFFFFD, TL=FFFFFFFE, TCON=3 -> TL reads FFFFFFFF on the next cycle, then FFFFFFFD; status=1 after the wrap edge; oIrq=1 one cycle later; TL continues FFFFFFFE, FFFFFFFF, and wraps again.
3. With status=1, write TCON=6 -> status clears and enable drops; oIrq=0 next cycle; TL holds its value. Repeat with the clear landing exactly on an overflow edge -> status remains 1.
4. SCAN_DIV=2, write DIGI=0x1234 -> oDigi cycles E99 (4), DB0 (3), BA4 (2), 7F9 (1), each for 2 cycles, repeating.
5. Bus decode: read BASE+0x20 -> oHit=0, oRdData=0. Write 0xFFFFFFFF to 0x14 and 0x0C -> no change to SYSTICK; 0x0C reads 0. Write 0xABCD0123 to 0x10 -> 0x10 reads 0x00000123.
6. Assert iRst during an active count with iWr to TL in the same cycle -> TL=0, TCON=0, oDigi=12'hEC0 on the next edge.
